hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage RISC-V core. It generates the write enables, flushes
//  and bubble controls that the IF/ID, ID/EX and EX/MEM pipeline registers consume.
//  It handles four hazards: load-use stalls, taken-branch flushes, multi-cycle vector ops held in
//  EX, and data-memory wait states. It also keeps wrap-around stall and flush event counters.
// PARAMETERS
//  VEC_LAT  4   cycles a vector op (is_vector) occupies EX; legal range 1..15
//  CNT_W    32  width of the performance counters
// PORTS
//  clk             in   1      core clock; all state updates on posedge
//  reset_n         in   1      asynchronous, active-low reset
//  id_rs1          in   5      rs1 of instruction in ID
//  id_rs2          in   5      rs2 of instruction in ID
//  id_uses_rs1     in   1      ID instruction reads rs1
//  id_uses_rs2     in   1      ID instruction reads rs2
//  ex_mem_read     in   1      instruction in EX is a load
//  ex_rd           in   5      rd of instruction in EX
//  ex_is_vector    in   1      instruction in EX is a vector op
//  ex_branch_taken in   1      branch/jump in EX resolved taken
//  mem_stall       in   1      data memory not ready; freezes whole pipeline
//  pc_write        out  1      PC update enable
//  if_id_write     out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID loads NOP (0x00000013)
//  id_ex_write     out  1      ID/EX load enable
//  id_ex_flush     out  1      ID/EX loads bubble (controls zeroed)
//  ex_mem_bubble   out  1      EX/MEM loads reg_write=mem_read=mem_write=0
//  vec_busy        out  1      vector op currently held in EX
//  stall_cnt       out  CNT_W  cycles with pc_write==0 since reset
//  flush_cnt       out  CNT_W  cycles with if_id_flush==1 since reset
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-low.
//  - Reset state: while reset_n==0, state=RUN, vcnt=0, stall_cnt=0, flush_cnt=0.
//    All enables, flushes, ex_mem_bubble and vec_busy read 0.
//  - Output timing: control outputs are combinational from state and inputs, so they act in the
//    same cycle. Only the FSM, vcnt and the counters are registered.
//  - Defaults (no hazard): pc_write=if_id_write=id_ex_write=1; all flushes and bubbles 0.
//  - Priority, highest first: mem_stall > ex_branch_taken > vector hold > load-use.
//  - mem_stall=1: all write enables 0, flushes and bubble 0, FSM and vcnt frozen.
//    stall_cnt increments.
//  - Taken branch (RUN state, no mem_stall):
//    if_id_flush=1 and id_ex_flush=1 for that cycle. PC enables stay 1.
//    A branch flush is never combined with a load-use stall.
//  - Load-use:
//    condition = ex_mem_read & ex_rd!=0 &
//      ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//    Response: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per match.
//  - FSM states RUN and VEC:
//    RUN->VEC when ex_is_vector & !ex_branch_taken & !mem_stall & VEC_LAT>1.
//    On that edge vcnt<=VEC_LAT-2.
//    In VEC: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, vec_busy=1.
//    In VEC, vcnt decrements each non-stalled cycle.
//    VEC->RUN on the edge where vcnt==0. The vector result enters EX/MEM on the following cycle
//    (bubble=0).
//  - Vector op timing: it therefore occupies EX for exactly VEC_LAT cycles.
//    VEC_LAT==1 never enters VEC.
//  - Branches in VEC: ex_branch_taken is ignored, because the EX instruction is a vector op.
//  - Counters: stall_cnt increments when pc_write==0; flush_cnt increments when if_id_flush==1.
//    Both wrap from all-ones to 0. A cycle in which both hold increments both counters.
//  - Reset mid-vector: FSM returns to RUN and vcnt clears. No pending bubble survives reset.
// STRUCTURE
//  - Shared core package (riscv_pkg): NOP_INSTR=32'h00000013, state enum {RUN,VEC},
//    register index width constant REG_AW=5.
//  - One sub-module, hazard_evt_counter (CNT_W wrap counter with inc and async active-low clear),
//    instantiated twice.
//  - Load-use compare and priority mux are inline.
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles with all inputs random.
//     -> all outputs 0, counters 0; after release, defaults apply and pc_write=1.
//  2. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
//     -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cnt=1.
//     Same stimulus with ex_rd=0 -> no stall.
//  3. Taken branch: ex_branch_taken=1 for one cycle.
//     -> if_id_flush=id_ex_flush=1, pc_write=1, flush_cnt+1.
//     With simultaneous load-use match -> branch response only.
//  4. Vector with VEC_LAT=4: ex_is_vector=1 in RUN.
//     -> vec_busy=1 and ex_mem_bubble=1 for 3 cycles, stall_cnt+3, then RUN.
//     Add mem_stall=1 for 2 cycles mid-op -> hold extended to 5 cycles.
//  5. Reset mid-VEC: assert reset_n=0 during the second busy cycle.
//     -> vec_busy=0 immediately (asynchronously); after release, state RUN.
//  6. Counter wrap with CNT_W=4: force 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the hazard controller state type
package riscv_pkg;
  localparam int REG_AW = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, VEC} state_t;
endpackage

// File: rtl/hazard_evt_counter.sv
// hazard_evt_counter: W-bit wrap-around event counter; ports clk, clr_n (async active-low clear), inc, cnt
module hazard_evt_counter
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_cnt <= '0;
    else if (inc) r_cnt <= r_cnt + 1'b1;
  assign cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use, branch flush, vector hold, mem wait) with stall/flush counters
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int VEC_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_vector,
  input  logic              ex_branch_taken,
  input  logic              mem_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_bubble,
  output logic              vec_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_t     r_state;
  logic [3:0] r_vcnt;
  logic       w_match, w_vec, w_free, w_branch, w_lu;
  assign w_match = ex_mem_read & (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign w_vec    = r_state == VEC;
  // w_free: reset released, memory ready and no vector op held; only then do branch/load-use act
  assign w_free   = reset_n & !mem_stall & !w_vec;
  assign w_branch = w_free & ex_branch_taken;
  assign w_lu     = w_free & !ex_branch_taken & w_match;
  assign pc_write      = w_free & !w_lu;
  assign if_id_write   = w_free & !w_lu;
  assign id_ex_write   = w_free;
  assign if_id_flush   = w_branch;
  assign id_ex_flush   = w_branch | w_lu;
  assign ex_mem_bubble = reset_n & w_vec & !mem_stall;
  assign vec_busy      = reset_n & w_vec;
  // The op's first EX cycle is spent in RUN, so VEC covers the remaining VEC_LAT-1 cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= RUN;
      r_vcnt  <= '0;
    end else if (!mem_stall) begin
      if (r_state == RUN) begin
        if (ex_is_vector && !ex_branch_taken && VEC_LAT > 1) begin
          r_state <= VEC;
          r_vcnt  <= 4'(VEC_LAT - 2);
        end
      end else if (r_vcnt == '0) r_state <= RUN;
      else r_vcnt <= r_vcnt - 1'b1;
    end
  hazard_evt_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n(reset_n), .inc(!pc_write), .cnt(stall_cnt)
  );
  hazard_evt_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .clr_n(reset_n), .inc(if_id_flush), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of hazard_ctrl (VEC_LAT=4, CNT_W=4) plus reset and wrap sequences
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_vector, ex_branch_taken, mem_stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, vec_busy;
  logic [3:0] stall_cnt, flush_cnt;
  always #5 clk = ~clk;
  hazard_ctrl #(.VEC_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_vector(ex_is_vector),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .vec_busy(vec_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  // expected output order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, vec_busy}
  localparam logic [6:0] DEF  = 7'b1101000;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] MS   = 7'b0000000;
  localparam logic [6:0] HOLD = 7'b0000011;
  localparam logic [6:0] MSV  = 7'b0000001;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [4:0] rd;
    logic       vec, br, ms;
    logic [6:0] e;
  } vec_t;
  vec_t tbl[$];
  int n = 0, bad = 0;
  logic [3:0] se, fe;
  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int mr, int rd,
                              int vec, int br, int ms, logic [6:0] e);
    vec_t t;
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'(u1); t.u2 = 1'(u2); t.mr = 1'(mr);
    t.rd = 5'(rd); t.vec = 1'(vec); t.br = 1'(br); t.ms = 1'(ms); t.e = e;
    return t;
  endfunction
  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, vec_busy};
  endfunction
  task automatic drive(input vec_t t);
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_uses_rs1 = t.u1; id_uses_rs2 = t.u2;
    ex_mem_read = t.mr; ex_rd = t.rd; ex_is_vector = t.vec; ex_branch_taken = t.br; mem_stall = t.ms;
  endtask
  task automatic chk_outs(input string nm, input logic [6:0] want);
    n++;
    if (outs() !== want) begin
      bad++;
      $display("FAIL %s outs got=%b want=%b", nm, outs(), want);
    end
  endtask
  task automatic chk_cnts(input string nm);
    n++;
    if (stall_cnt !== se || flush_cnt !== fe) begin
      bad++;
      $display("FAIL %s cnts got stall=%0d flush=%0d want stall=%0d flush=%0d", nm, stall_cnt, flush_cnt, se, fe);
    end
  endtask
  task automatic step(input vec_t t, input string nm);
    @(negedge clk);
    drive(t);
    #1 chk_outs(nm, t.e);
    @(posedge clk);
    #1;
    if (!t.e[6]) se = se + 1'b1;
    if (t.e[4]) fe = fe + 1'b1;
    chk_cnts(nm);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    se = '0; fe = '0;
    for (int i = 0; i < 3; i++) begin
      {id_rs1, id_rs2, ex_rd} = 15'($urandom);
      {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_vector, ex_branch_taken, mem_stall} = 6'($urandom);
      #1 chk_outs($sformatf("reset%0d", i), 7'b0);
      chk_cnts($sformatf("reset%0d", i));
      @(negedge clk);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    reset_n = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF), "post_reset");
  endtask
  initial begin
    reset_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    do_reset();
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(5, 0, 1, 0, 1, 5, 0, 0, 0, LU));
    tbl.push_back(mk(5, 0, 1, 0, 1, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 7, 0, 1, 1, 7, 0, 0, 0, LU));
    tbl.push_back(mk(0, 7, 0, 0, 1, 7, 0, 0, 0, DEF));
    tbl.push_back(mk(5, 0, 1, 0, 0, 5, 0, 0, 0, DEF));
    tbl.push_back(mk(9, 3, 0, 1, 1, 9, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, BR));
    tbl.push_back(mk(5, 0, 1, 0, 1, 5, 0, 1, 0, BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, MS));
    tbl.push_back(mk(5, 0, 1, 0, 1, 5, 0, 1, 1, MS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD));
    tbl.push_back(mk(5, 0, 1, 0, 1, 5, 1, 0, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, MSV));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, MSV));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, MS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, DEF), "mid_vec_start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD), "mid_vec_busy1");
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD));
    #1 chk_outs("mid_vec_busy2", HOLD);
    reset_n = 1'b0;
    se = '0; fe = '0;
    #1 chk_outs("mid_vec_async_reset", 7'b0);
    @(posedge clk);
    #1 chk_cnts("mid_vec_reset_cnts");
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    reset_n = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF), "mid_vec_after_reset");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF), "mid_vec_run");
    do_reset();
    repeat (17) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, MS), "wrap_stall");
    n++;
    if (stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL wrap stall_cnt got=%0d want=1", stall_cnt);
    end
    $display("test done: total=%0d bad=%0d", n, bad);
    $finish;
  end
endmodule
